// File: rtl/riscmakers_arb_pkg.sv
// riscmakers_arb_pkg
// Shared types and constants for the memory arbiter slice.
//   arb_state_t     : arbiter FSM encoding (IDLE / REQ / WAIT)
//   ICACHE_REQ      : requester index of the icache miss path
//   DCACHE_REQ      : requester index of the bypassing dcache
//   ARB_TIMEOUT_CYC : default WAIT-cycle limit before forced completion
package riscmakers_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  localparam int unsigned ICACHE_REQ      = 0;
  localparam int unsigned DCACHE_REQ      = 1;
  localparam int unsigned ARB_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/riscmakers_rr_picker.sv
// riscmakers_rr_picker
// Two-way winner selection for the memory arbiter.
// Build option: RISCMAKERS_ARB_RR_EN
//   defined   : on a tie, the requester that was not granted last wins
//   undefined : fixed priority, the dcache (requester 1) wins every tie
// Ports:
//   req_i  [2] : per-requester request
//   last_i     : requester granted most recently (round-robin build only)
//   win_o      : index of the selected requester
//   gnt_o  [2] : one-hot grant, all zero when nothing requests
module riscmakers_rr_picker
  import riscmakers_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef RISCMAKERS_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic       win_o,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
`ifdef RISCMAKERS_ARB_RR_EN
    if (&req_i) begin
      win_o = ~last_i;
    end else begin
      win_o = req_i[DCACHE_REQ];
    end
`else
    win_o = req_i[DCACHE_REQ];
`endif
    if (|req_i) begin
      gnt_o[win_o] = 1'b1;
    end
  end

endmodule

// File: rtl/riscmakers_mem_arbiter.sv
// riscmakers_mem_arbiter
// Shares one memory request/return port between the icache miss path
// (requester 0) and the bypassing dcache (requester 1). One transaction is
// outstanding at a time; the return is steered to the owner by tid. A
// timeout recovers the owner if memory never answers, and an abort lets the
// owner walk away while the arbiter still absorbs the in-flight return.
// Build option: RISCMAKERS_ARB_RR_EN (round-robin ties, else dcache priority)
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   req_i/paddr_i/we_i/size_i/wdata_i : per-requester request and payload
//   abort_i                : owner abandons its outstanding transaction
//   ack_o                  : one-cycle grant, payload captured that cycle
//   rtrn_vld_o/rtrn_data_o : one-cycle completion to the owner
//   mem_req_o/mem_ack_i    : memory request handshake
//   mem_paddr_o/mem_we_o/mem_size_o/mem_wdata_o/mem_tid_o : registered payload
//   mem_rtrn_vld_i/mem_rtrn_tid_i/mem_rtrn_data_i : memory return
//   busy_o                 : arbiter not idle
//   timeout_o              : one-cycle pulse on forced completion
module riscmakers_mem_arbiter
  import riscmakers_arb_pkg::*;
#(
  parameter int unsigned PADDR_W     = 34,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned TID_W       = 2,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_i,
  input  logic [1:0][PADDR_W-1:0] paddr_i,
  input  logic [1:0]              we_i,
  input  logic [1:0][2:0]         size_i,
  input  logic [1:0][DATA_W-1:0]  wdata_i,
  input  logic [1:0]              abort_i,
  output logic [1:0]              ack_o,
  output logic [1:0]              rtrn_vld_o,
  output logic [LINE_W-1:0]       rtrn_data_o,
  output logic                    mem_req_o,
  input  logic                    mem_ack_i,
  output logic [PADDR_W-1:0]      mem_paddr_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic [TID_W-1:0]        mem_tid_o,
  input  logic                    mem_rtrn_vld_i,
  input  logic [TID_W-1:0]        mem_rtrn_tid_i,
  input  logic [LINE_W-1:0]       mem_rtrn_data_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state_q, state_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               we_q, we_d;
  logic [2:0]         size_q, size_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               owner_q, owner_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               rtrn_match;
  logic               win;
  logic [1:0]         gnt;

`ifdef RISCMAKERS_ARB_RR_EN
  logic               last_q, last_d;
`endif

  riscmakers_rr_picker u_picker (
    .req_i  (req_i),
`ifdef RISCMAKERS_ARB_RR_EN
    .last_i (last_q),
`endif
    .win_o  (win),
    .gnt_o  (gnt)
  );

  assign rtrn_match  = mem_rtrn_vld_i && (mem_rtrn_tid_i == TID_W'(owner_q));
  assign cnt_inc     = cnt_q + CNT_W'(1);

  assign busy_o      = (state_q != ARB_IDLE);
  assign mem_paddr_o = paddr_q;
  assign mem_we_o    = we_q;
  assign mem_size_o  = size_q;
  assign mem_wdata_o = wdata_q;
  assign mem_tid_o   = TID_W'(owner_q);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    we_d        = we_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
`ifdef RISCMAKERS_ARB_RR_EN
    last_d      = last_q;
`endif
    ack_o       = '0;
    rtrn_vld_o  = '0;
    rtrn_data_o = '0;
    mem_req_o   = 1'b0;
    timeout_o   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          ack_o   = gnt;
          paddr_d = paddr_i[win];
          we_d    = we_i[win];
          size_d  = size_i[win];
          wdata_d = wdata_i[win];
          owner_d = win;
          drop_d  = 1'b0;
`ifdef RISCMAKERS_ARB_RR_EN
          last_d  = win;
`endif
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        // An aborted request is still presented until memory takes it.
        mem_req_o = 1'b1;
        if (abort_i[owner_q]) begin
          drop_d = 1'b1;
        end
        if (mem_ack_i) begin
          cnt_d = '0;
          if (rtrn_match) begin
            if (!drop_q) begin
              rtrn_vld_o[owner_q] = 1'b1;
              rtrn_data_o         = mem_rtrn_data_i;
            end
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end

      ARB_WAIT: begin
        cnt_d = cnt_inc;
        if (abort_i[owner_q]) begin
          drop_d = 1'b1;
        end
        // A matching return wins over a timeout landing in the same cycle.
        if (rtrn_match) begin
          if (!drop_q) begin
            rtrn_vld_o[owner_q] = 1'b1;
            rtrn_data_o         = mem_rtrn_data_i;
          end
          state_d = ARB_IDLE;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          timeout_o = 1'b1;
          if (!drop_q) begin
            rtrn_vld_o[owner_q] = 1'b1;
          end
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      paddr_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef RISCMAKERS_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
`ifdef RISCMAKERS_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
